// File: rtl/axi4_lite_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_pkg
// Brief    : Shared AXI4-Lite constants and the read-master state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package axi4_lite_pkg;

  // AXI response codes; bit 1 set means the slave reported an error
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Unprivileged, secure, data access
  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

  // Read-master transaction phases
  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2,
    RD_RESP = 2'd3
  } rd_state_t;

endpackage : axi4_lite_pkg
`default_nettype wire

// File: rtl/axi4_lite_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_watchdog
// Brief    : Cycle watchdog for AXI4-Lite masters. 'clear' restarts the count,
//            'start' counts one cycle of an open watch window, and 'expired'
//            flags the LIMIT-th counted cycle so the master can abort on it.
// Revision : 1.0 - initial release
// ============================================================================
module axi4_lite_watchdog #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clear,
  output logic expired
);

  localparam int            c_cw   = $clog2(LIMIT + 1);
  localparam logic [c_cw-1:0] c_last = c_cw'(LIMIT - 1);

  logic [c_cw-1:0] r_count;

  // Count open-window cycles; saturate on the last one so it never wraps
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_count <= '0;
    end else if (start && (r_count != c_last)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expired = start && (r_count == c_last);

endmodule : axi4_lite_watchdog
`default_nettype wire

// File: rtl/axi4_lite_read_master.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_read_master
// Brief    : Single-outstanding AXI4-Lite read initiator. Takes one client
//            request, runs AR then R, and holds the result for the client.
//            Optional watchdog abort enabled by macro AXI_RD_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module axi4_lite_read_master
  import axi4_lite_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     axi_clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  output logic [ADDRESS_WIDTH-1:0] araddr,
  output logic [2:0]               arprot,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [DATA_WIDTH-1:0]    rdata,
  input  logic [1:0]               rresp,
  input  logic                     rvalid,
  output logic                     rready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_data,
  output logic                     rsp_err,
  output logic                     rsp_timeout
);

  rd_state_t                r_state;
  rd_state_t                w_state_next;
  logic                     r_req_ready;
  logic [ADDRESS_WIDTH-1:0] r_araddr;
  logic                     r_arvalid;
  logic                     r_rready;
  logic                     r_rsp_valid;
  logic [DATA_WIDTH-1:0]    r_rsp_data;
  logic                     r_rsp_err;
  logic                     w_accept;
  logic                     w_capture;
  logic                     w_abort;
  logic                     w_wd_clear;
  logic                     w_wd_run;
  logic                     w_expired;
  logic                     w_unused_ok;

  // Handshakes are judged on the registered valid/ready we actually drive
  assign w_accept = (r_state == RD_IDLE) && req_valid;

  // State register
  always_ff @(posedge axi_clk) begin
    if (reset) r_state <= RD_IDLE;
    else       r_state <= w_state_next;
  end

  // Next state plus the one-cycle strobes that steer the output registers
  always_comb begin
    w_state_next = r_state;
    w_wd_clear   = 1'b0;
    w_wd_run     = 1'b0;
    w_capture    = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      RD_IDLE: begin
        if (req_valid) begin
          w_state_next = RD_ADDR;
          w_wd_clear   = 1'b1;
        end
      end
      RD_ADDR: begin
        w_wd_run = 1'b1;
        if (r_arvalid && arready) begin
          w_state_next = RD_DATA;
        end else if (w_expired) begin
          w_state_next = RD_RESP;
          w_abort      = 1'b1;
        end
      end
      RD_DATA: begin
        w_wd_run = 1'b1;
        if (r_rready && rvalid) begin
          w_state_next = RD_RESP;
          w_capture    = 1'b1;
        end else if (w_expired) begin
          w_state_next = RD_RESP;
          w_abort      = 1'b1;
        end
      end
      RD_RESP: begin
        if (rsp_ready) w_state_next = RD_IDLE;
      end
      default: w_state_next = RD_IDLE;
    endcase
  end

  // Registered outputs follow the state being entered; data held otherwise
  always_ff @(posedge axi_clk) begin
    if (reset) begin
      r_req_ready <= 1'b1;
      r_araddr    <= '0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_req_ready <= (w_state_next == RD_IDLE);
      r_arvalid   <= (w_state_next == RD_ADDR);
      r_rready    <= (w_state_next == RD_DATA);
      r_rsp_valid <= (w_state_next == RD_RESP);
      if (w_accept) r_araddr <= req_addr;
      if (w_capture) begin
        r_rsp_data <= rdata;
        r_rsp_err  <= rresp[1];
      end else if (w_abort) begin
        r_rsp_data <= '0;
        r_rsp_err  <= 1'b1;
      end
    end
  end

`ifdef AXI_RD_TIMEOUT_EN
  logic r_rsp_timeout;

  axi4_lite_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (axi_clk),
    .rst     (reset),
    .start   (w_wd_run),
    .clear   (w_wd_clear),
    .expired (w_expired)
  );

  // Timeout flag travels with the response it belongs to
  always_ff @(posedge axi_clk) begin
    if (reset)          r_rsp_timeout <= 1'b0;
    else if (w_capture) r_rsp_timeout <= 1'b0;
    else if (w_abort)   r_rsp_timeout <= 1'b1;
  end

  assign rsp_timeout = r_rsp_timeout;
  assign w_unused_ok = rresp[0];
`else
  localparam int c_unused_timeout = TIMEOUT_CYCLES;

  assign w_expired   = 1'b0;
  assign rsp_timeout = 1'b0;
  assign w_unused_ok = ^{rresp[0], w_wd_run, w_wd_clear, c_unused_timeout[0]};
`endif

  assign req_ready = r_req_ready;
  assign araddr    = r_araddr;
  assign arprot    = AXI_PROT_DEFAULT;
  assign arvalid   = r_arvalid;
  assign rready    = r_rready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;

endmodule : axi4_lite_read_master
`default_nettype wire

// File: tb/tb_axi4_lite_read_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_lite_read_master
// Brief    : Scoreboard bench for axi4_lite_read_master with a behavioural
//            AXI4-Lite slave. Watchdog scenario included with AXI_RD_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi4_lite_read_master;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        to;
  } exp_t;

  logic        axi_clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_addr;
  logic [1:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        rsp_timeout;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int rsp_first_cyc = 0;
  int rsp_hs_cyc = 0;
  int last_ar_len = 0;
  int g_ar_delay = 0;
  int g_r_delay = 0;
  bit s_rand = 0;
  bit rsp_rand = 0;
  bit allow_abort = 0;

  logic [31:0] mem [4];
  exp_t        exp_q[$];
  logic [1:0]  resp_q[$];

  axi4_lite_read_master dut (
    .axi_clk     (axi_clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .araddr      (araddr),
    .arprot      (arprot),
    .arvalid     (arvalid),
    .arready     (arready),
    .rdata       (rdata),
    .rresp       (rresp),
    .rvalid      (rvalid),
    .rready      (rready),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout)
  );

  always #5 axi_clk = ~axi_clk;

  // Cycle index used for latency measurements
  always @(posedge axi_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural slave: arready after g_ar_delay arvalid cycles, rvalid after g_r_delay
  initial begin
    int         st;
    int         cnt;
    int         ard;
    int         rd;
    logic [1:0] sa;
    logic [1:0] sr;
    logic       m_arv, m_arr, m_rv, m_rr, m_rst;
    logic [1:0] m_addr;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0;
    st = 0; cnt = 0; ard = 0; rd = 0; sa = '0; sr = '0;
    forever begin
      @(negedge axi_clk);
      m_arv = arvalid; m_arr = arready; m_rv = rvalid; m_rr = rready;
      m_rst = reset; m_addr = araddr;
      @(posedge axi_clk); #1;
      if (m_rst) begin
        st = 0; cnt = 0; arready = 1'b0; rvalid = 1'b0;
        ard = g_ar_delay;
      end else if (st == 0) begin
        if (m_arv && m_arr) begin
          sa = m_addr;
          sr = (resp_q.size() > 0) ? resp_q.pop_front() : 2'b00;
          rd = s_rand ? int'($urandom_range(0, 3)) : g_r_delay;
          cnt = 0; st = 1; arready = 1'b0;
          if (rd == 0) rvalid = 1'b1;
        end else begin
          if (!s_rand) ard = g_ar_delay;
          if (m_arv) cnt++;
          arready = (cnt >= ard);
        end
      end else begin
        if (m_rv && m_rr) begin
          rvalid = 1'b0; st = 0; cnt = 0;
          ard = s_rand ? int'($urandom_range(0, 3)) : g_ar_delay;
          arready = (ard == 0);
        end else if (!rvalid) begin
          cnt++;
          if (cnt >= rd) rvalid = 1'b1;
        end
      end
      rdata = rvalid ? mem[sa] : $urandom();
      rresp = rvalid ? sr : 2'($urandom_range(0, 3));
    end
  end

  // Random client back-pressure
  initial begin
    forever begin
      @(posedge axi_clk); #1;
      if (rsp_rand) rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: AR stability, response hold and scoreboard compare on handshake
  initial begin
    logic        pv, par_v, par_hs;
    logic [1:0]  paddr;
    logic [31:0] pdata;
    logic        perr;
    int          ar_len;
    exp_t        e;
    pv = 0; par_v = 0; par_hs = 0; paddr = '0; pdata = '0; perr = 0; ar_len = 0;
    forever begin
      @(negedge axi_clk);
      if (reset) begin
        pv = 0; par_v = 0; par_hs = 0; ar_len = 0;
      end else begin
        if (par_v && !par_hs && !allow_abort) begin
          check("arvalid_hold", arvalid, 1'b1);
          check("araddr_hold", araddr, paddr);
        end
        if (arvalid) ar_len++;
        if (arvalid && arready) begin
          last_ar_len = ar_len; ar_len = 0;
        end else if (!arvalid && ar_len > 0) begin
          last_ar_len = ar_len; ar_len = 0;
        end
        par_v = arvalid; par_hs = arvalid && arready; paddr = araddr;
        if (pv) begin
          check("rsp_valid_hold", rsp_valid, 1'b1);
          check("rsp_data_hold", rsp_data, pdata);
          check("rsp_err_hold", rsp_err, perr);
        end
        if (rsp_valid) begin
          if (!pv) rsp_first_cyc = cyc;
          if (rsp_ready) begin
            if (exp_q.size() == 0) begin
              n_cmp++; n_err++;
              $display("FAIL unexpected_rsp: data %0h err %0b with nothing expected", rsp_data, rsp_err);
            end else begin
              e = exp_q.pop_front();
              check("rsp_data", rsp_data, e.data);
              check("rsp_err", rsp_err, e.err);
              check("rsp_timeout", rsp_timeout, e.to);
            end
            rsp_hs_cyc = cyc;
            pv = 0;
          end else begin
            pv = 1; pdata = rsp_data; perr = rsp_err;
          end
        end else begin
          pv = 0;
        end
      end
    end
  end

  // Issue one request; returns the cycle index in which it was accepted
  task automatic issue(input logic [1:0] a, input logic [1:0] r, input logic [31:0] ed,
                       input logic ee, input logic et, output int acc);
    exp_t e;
    e.data = ed; e.err = ee; e.to = et;
    exp_q.push_back(e);
    resp_q.push_back(r);
    req_addr = a; req_valid = 1'b1;
    acc = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge axi_clk);
      if (req_ready) begin
        acc = cyc;
        break;
      end
    end
    @(posedge axi_clk); #1;
    req_valid = 1'b0; req_addr = 2'($urandom_range(0, 3));
    if (acc < 0) begin
      n_cmp++; n_err++;
      $display("FAIL req_accept: request to %0d never accepted", a);
    end
  endtask

  task automatic read(input logic [1:0] a, input logic [1:0] r, output int acc);
    issue(a, r, mem[a], r[1], 1'b0, acc);
  endtask

  task automatic wait_drain();
    int k;
    for (k = 0; k < 600; k++) begin
      @(negedge axi_clk);
      if (exp_q.size() == 0) break;
    end
    if (exp_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain: %0d responses outstanding", exp_q.size());
      exp_q.delete();
    end
    @(posedge axi_clk); #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge axi_clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    int acc, acc2, seen, k;
    mem[0] = 32'hA5A5_A5A5;
    mem[1] = 32'h0000_000F;
    mem[2] = 32'hDEAD_BEEF;
    mem[3] = $urandom();
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge axi_clk);
    @(negedge axi_clk);
    check("rst_arvalid", arvalid, 1'b0);
    check("rst_rready", rready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_rsp_timeout", rsp_timeout, 1'b0);
    check("rst_araddr", araddr, 2'b00);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("arprot", arprot, 3'b000);
    @(posedge axi_clk); #1;
    reset = 1'b0;
    @(posedge axi_clk); #1;

    // Minimum latency read with arready/rvalid immediate
    read(2'd0, 2'b00, acc);
    wait_drain();
    check("t1_latency", rsp_first_cyc - acc, 3);

    // arready held off for 5 arvalid cycles
    g_ar_delay = 5;
    read(2'd1, 2'b00, acc);
    wait_drain();
    check("t2_arvalid_cycles", last_ar_len, 6);
    g_ar_delay = 0;

    // SLVERR response held under client back-pressure
    rsp_ready = 1'b0;
    read(2'd2, 2'b10, acc);
    seen = 0;
    for (k = 0; k < 50; k++) begin
      @(negedge axi_clk);
      if (rsp_valid) begin seen = 1; break; end
    end
    check("t3_rsp_seen", seen, 1);
    for (k = 0; k < 4; k++) begin
      @(negedge axi_clk);
      check("t3_rsp_hold", rsp_valid, 1'b1);
    end
    @(posedge axi_clk); #1;
    rsp_ready = 1'b1;
    wait_drain();

    // Back-to-back reads
    read(2'd0, 2'b00, acc);
    read(2'd1, 2'b01, acc2);
    check("t4_next_accept", acc2, rsp_hs_cyc + 1);
    wait_drain();

    // Reset while waiting for read data
    g_r_delay = 10;
    read(2'd3, 2'b00, acc);
    seen = 0;
    for (k = 0; k < 50; k++) begin
      @(negedge axi_clk);
      if (rready) begin seen = 1; break; end
    end
    check("t5_in_data", seen, 1);
    @(posedge axi_clk); #1;
    exp_q.delete(); resp_q.delete();
    pulse_reset();
    @(negedge axi_clk);
    check("t5_rready", rready, 1'b0);
    check("t5_rsp_valid", rsp_valid, 1'b0);
    check("t5_req_ready", req_ready, 1'b1);
    check("t5_arvalid", arvalid, 1'b0);
    g_r_delay = 0;
    seen = 0;
    for (k = 0; k < 15; k++) begin
      @(negedge axi_clk);
      if (rsp_valid) seen++;
    end
    check("t5_no_rsp", seen, 0);
    @(posedge axi_clk); #1;

    // Randomized traffic with random slave delays and client back-pressure
    s_rand = 1; rsp_rand = 1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge axi_clk); #1;
      end
      read(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), acc);
    end
    wait_drain();
    s_rand = 0; rsp_rand = 0; rsp_ready = 1'b1;
    repeat (3) begin
      @(posedge axi_clk); #1;
    end

`ifdef AXI_RD_TIMEOUT_EN
    // Hung slave: arready never rises
    g_ar_delay = 100000; allow_abort = 1;
    issue(2'd1, 2'b00, 32'h0, 1'b1, 1'b1, acc);
    wait_drain();
    check("t6_arvalid_cycles", last_ar_len, 16);
    check("t6_arvalid_low", arvalid, 1'b0);
    resp_q.delete();
    g_ar_delay = 0;
    pulse_reset();
    allow_abort = 0;
    read(2'd0, 2'b00, acc);
    wait_drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Absolute bound on run time
  initial begin
    #300000;
    n_cmp++; n_err++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_axi4_lite_read_master
`default_nettype wire
